// File: rtl/dynamics_pkg.sv
// Shared definitions for the note dynamics stages (attack and release).
package dynamics_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int GAIN_W     = 4;
  localparam logic [GAIN_W-1:0] GAIN_FULL = 4'd8;
  localparam int GAIN_SHIFT = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2
  } state_e;

endpackage

// File: rtl/attack_step_timer.sv
// Step timer for the attack ramp: latches the step period on each new note
// and counts sample strobes, flagging the strobe that ends a step.
module attack_step_timer #(
  parameter int STEP_SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_note,
  input  logic [5:0] note_duration,
  input  logic       step_en,
  output logic       step_tick
);

  // Wide enough for the largest period, 64 << STEP_SHIFT.
  localparam int CNT_W = 7 + STEP_SHIFT;

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             at_end;

  assign at_end    = (step_cnt_q == period_q - CNT_W'(1));
  assign step_tick = step_en && at_end;

  // Period latch and step counter; a new note restarts the count and wins over a strobe.
  always_comb begin
    period_d   = period_q;
    step_cnt_d = step_cnt_q;
    if (new_note) begin
      period_d   = (CNT_W'(note_duration) + CNT_W'(1)) << STEP_SHIFT;
      step_cnt_d = '0;
    end else if (step_en) begin
      step_cnt_d = at_end ? '0 : step_cnt_q + CNT_W'(1);
    end
  end

  // Timer registers; the period resets to 1 so it is never zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q   <= CNT_W'(1);
      step_cnt_q <= '0;
    end else begin
      period_q   <= period_d;
      step_cnt_q <= step_cnt_d;
    end
  end

endmodule

// File: rtl/note_attack.sv
// Attack-envelope shaper: ramps per-sample gain 0/8..8/8 after each new note,
// then holds unity gain until the next note.
//
//  state      | meaning
//  -----------+------------------------------------------------
//  ST_IDLE    | no note yet; level 0, strobes produce 0
//  ST_ATTACK  | ramping; level 0..7, steps on timer ticks
//  ST_SUSTAIN | level 8 (passthrough); waits for next new_note
module note_attack #(
  parameter int SAMPLE_W   = 16,
  parameter int STEP_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [5:0]                 note_duration,
  input  logic                       new_note,
  input  logic                       generate_next_sample,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic signed [SAMPLE_W-1:0] final_sample,
  output logic                       sample_valid,
  output logic                       attack_done
);

  import dynamics_pkg::*;

  localparam int PROD_W = SAMPLE_W + GAIN_W;

  state_e                     state_q, state_d;
  logic [GAIN_W-1:0]          level_q, level_d;
  logic [GAIN_W-1:0]          scale_level;
  logic                       step_en;
  logic                       step_tick;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   prod_shift;
  logic signed [SAMPLE_W-1:0] final_sample_q, final_sample_d;
  logic                       sample_valid_q, sample_valid_d;
  logic                       attack_done_q, attack_done_d;

  // The counter only advances on strobes inside the ramp that are not overridden by a new note.
  assign step_en = generate_next_sample && !new_note && (state_q == ST_ATTACK);

  attack_step_timer #(
    .STEP_SHIFT (STEP_SHIFT)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .new_note      (new_note),
    .note_duration (note_duration),
    .step_en       (step_en),
    .step_tick     (step_tick)
  );

  // Next-state and level: new_note restarts the ramp from any state.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (new_note) begin
      state_d = ST_ATTACK;
      level_d = '0;
    end else begin
      case (state_q)
        ST_ATTACK: begin
          if (step_tick) begin
            level_d = level_q + 4'd1;
            if (level_d == GAIN_FULL) state_d = ST_SUSTAIN;
          end
        end
        default: ;
      endcase
    end
  end

  // Scale the strobed sample by the pre-increment level; a coincident new note scales by 0.
  always_comb begin
    scale_level    = new_note ? '0 : level_q;
    prod           = PROD_W'(sample) * PROD_W'($signed({1'b0, scale_level}));
    prod_shift     = prod >>> GAIN_SHIFT;
    final_sample_d = generate_next_sample ? SAMPLE_W'(prod_shift) : final_sample_q;
    sample_valid_d = generate_next_sample;
    attack_done_d  = (state_d == ST_SUSTAIN);
  end

  // State, level and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      level_q        <= '0;
      final_sample_q <= '0;
      sample_valid_q <= 1'b0;
      attack_done_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      final_sample_q <= final_sample_d;
      sample_valid_q <= sample_valid_d;
      attack_done_q  <= attack_done_d;
    end
  end

  assign final_sample = final_sample_q;
  assign sample_valid = sample_valid_q;
  assign attack_done  = attack_done_q;

endmodule
